// File: rtl/perf_counter_bank.sv
// perf_counter_bank: saturating per-channel event counters with
// snapshot-on-dump and a one-record-per-channel valid/ready drain.
module perf_counter_bank #(
  parameter int NUM_CH    = 8,
  parameter int INC_WIDTH = 4,
  parameter int CNT_WIDTH = 48,
  parameter int ID_WIDTH  = $clog2(NUM_CH)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [63:0]                 timer,
  input  logic                        log_enable,
  input  logic                        clean,
  input  logic                        dump,
  input  logic [NUM_CH*INC_WIDTH-1:0] inc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ID_WIDTH-1:0]         out_id,
  output logic [CNT_WIDTH-1:0]        out_value,
  output logic [63:0]                 out_timer,
  output logic                        out_last,
  output logic                        busy,
  output logic [7:0]                  dump_dropped
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_CH - 1);

  logic [0:0]           state;
  logic [CNT_WIDTH-1:0] cnt  [NUM_CH];
  logic [CNT_WIDTH-1:0] snap [NUM_CH];
  logic [CNT_WIDTH:0]   sum  [NUM_CH];
  logic [CNT_WIDTH-1:0] sat  [NUM_CH];
  logic [7:0]           drop_q;
  logic                 take;

  assign take = (state == IDLE) && dump;

  // one extra bit catches the carry that selects the saturated value
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i] = {1'b0, cnt[i]}
             + {{(CNT_WIDTH + 1 - INC_WIDTH){1'b0}},
                inc[i*INC_WIDTH +: INC_WIDTH]};
      sat[i] = sum[i][CNT_WIDTH] ? '1 : sum[i][CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]  <= '0;
        snap[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clean)
          cnt[i] <= '0;
        else if (log_enable)
          cnt[i] <= sat[i];
        if (take)
          snap[i] <= cnt[i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_id    <= '0;
      out_timer <= '0;
      drop_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (dump) begin
            state     <= DRAIN;
            out_id    <= '0;
            out_timer <= timer;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_id == LAST_ID)
              state <= IDLE;
            else
              out_id <= out_id + ID_WIDTH'(1);
          end
          if (dump && drop_q != 8'hff)
            drop_q <= drop_q + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = (state == DRAIN);
  assign out_valid    = busy;
  assign out_value    = snap[out_id];
  assign out_last     = busy && (out_id == LAST_ID);
  assign dump_dropped = drop_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: scoreboard plus table-driven checks of the
// perf counter bank, with a CNT_WIDTH=8 twin for saturation.
module tb_perf_counter_bank;

  localparam int N = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [63:0]   timer;
  logic          log_enable, clean, dump, out_ready;
  logic [N*4-1:0] inc;
  logic          out_valid, out_last, busy;
  logic [2:0]    out_id;
  logic [47:0]   out_value;
  logic [63:0]   out_timer;
  logic [7:0]    dump_dropped;

  logic          v8, l8, b8;
  logic [2:0]    id8;
  logic [7:0]    val8;
  logic [63:0]   tm8;
  logic [7:0]    dd8;

  perf_counter_bank dut (
    .clock(clock), .reset(reset), .timer(timer),
    .log_enable(log_enable), .clean(clean), .dump(dump),
    .inc(inc), .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_value(out_value),
    .out_timer(out_timer), .out_last(out_last),
    .busy(busy), .dump_dropped(dump_dropped)
  );

  perf_counter_bank #(.CNT_WIDTH(8)) u8 (
    .clock(clock), .reset(reset), .timer(timer),
    .log_enable(log_enable), .clean(clean), .dump(dump),
    .inc(inc), .out_valid(v8), .out_ready(out_ready),
    .out_id(id8), .out_value(val8),
    .out_timer(tm8), .out_last(l8),
    .busy(b8), .dump_dropped(dd8)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  id;
    logic [47:0] val;
    logic [63:0] tm;
    logic        last;
  } rec_t;

  typedef struct {
    int          ch;
    logic [3:0]  incv;
    int          ncyc;
    logic        le;
    logic [47:0] exp;
  } vec_t;

  rec_t        sb[$];
  vec_t        tab[5];
  logic [47:0] mc  [N];
  logic [47:0] got [N];
  logic        mbusy;
  logic [2:0]  mid;
  logic [7:0]  mdrop;
  int          total = 0;
  int          bad = 0;
  int          nrec = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic setinc(int ch, logic [3:0] v);
    inc = '0;
    inc[ch*4 +: 4] = v;
  endtask

  // check the visible outputs, advance the model over the coming edge
  task automatic tick();
    logic        wb;
    logic [48:0] s;
    rec_t        e;
    wb = mbusy;
    chk("out_valid", {63'd0, out_valid}, {63'd0, mbusy});
    chk("busy", {63'd0, busy}, {63'd0, mbusy});
    chk("u8 busy", {63'd0, b8}, {63'd0, mbusy});
    chk("dump_dropped", {56'd0, dump_dropped}, {56'd0, mdrop});
    if (mbusy) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard: record seen with none expected");
      end else begin
        e = sb[0];
        chk("rec id", {61'd0, out_id}, {61'd0, e.id});
        chk("rec value", {16'd0, out_value}, {16'd0, e.val});
        chk("rec timer", out_timer, e.tm);
        chk("rec last", {63'd0, out_last}, {63'd0, e.last});
        if (out_ready) begin
          got[e.id] = out_value;
          nrec++;
          void'(sb.pop_front());
        end
      end
      if (out_ready) begin
        if (mid == 3'(N - 1)) mbusy = 1'b0;
        else mid = mid + 3'd1;
      end
    end
    if (dump) begin
      if (wb) begin
        if (mdrop != 8'hff) mdrop = mdrop + 8'd1;
      end else begin
        for (int i = 0; i < N; i++) begin
          e.id = 3'(i);
          e.val = mc[i];
          e.tm = timer;
          e.last = (i == N - 1);
          sb.push_back(e);
        end
        mbusy = 1'b1;
        mid = 3'd0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (clean) mc[i] = '0;
      else if (log_enable) begin
        s = {1'b0, mc[i]} + {45'd0, inc[i*4 +: 4]};
        mc[i] = s[48] ? '1 : s[47:0];
      end
    end
    @(negedge clock);
    timer = timer + 64'd1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (mbusy && k < 100) begin
      tick();
      k++;
    end
    if (mbusy) begin
      total++;
      bad++;
      $display("FAIL drain: still busy after 100 cycles");
    end
  endtask

  task automatic pulse_dump();
    dump = 1'b1;
    tick();
    dump = 1'b0;
  endtask

  task automatic pulse_clean();
    inc = '0;
    clean = 1'b1;
    tick();
    clean = 1'b0;
  endtask

  task automatic main_stim();
    for (int c = 0; c < 10; c++) begin
      setinc(0, 4'd3);
      if (c < 2) inc[31:28] = 4'd15;
      tick();
    end
    inc = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int sin, stall, k;
    tab[0] = '{0, 4'd3, 10, 1'b1, 48'd30};
    tab[1] = '{1, 4'd9, 10, 1'b0, 48'd0};
    tab[2] = '{5, 4'd1, 1, 1'b1, 48'd1};
    tab[3] = '{2, 4'd15, 4, 1'b1, 48'd60};
    tab[4] = '{6, 4'd7, 0, 1'b1, 48'd0};

    reset = 1'b1;
    timer = 64'h0000_1000_0000_0000;
    log_enable = 1'b1;
    clean = 1'b0;
    dump = 1'b0;
    inc = '0;
    out_ready = 1'b1;
    mbusy = 1'b0;
    mid = 3'd0;
    mdrop = 8'd0;
    for (int i = 0; i < N; i++) begin
      mc[i] = '0;
      got[i] = '1;
    end
    repeat (2) @(negedge clock);
    chk("rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst out_last", {63'd0, out_last}, 64'd0);
    chk("rst out_id", {61'd0, out_id}, 64'd0);
    chk("rst out_timer", out_timer, 64'd0);
    chk("rst dropped", {56'd0, dump_dropped}, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // main drain with ready held high
    sin = nrec;
    main_stim();
    pulse_dump();
    drain();
    chk("main ch0", {16'd0, got[0]}, 64'd30);
    chk("main ch7", {16'd0, got[7]}, 64'd30);
    chk("main ch3", {16'd0, got[3]}, 64'd0);
    chk("main records", 64'(nrec - sin), 64'd8);

    // backpressure on id 2
    pulse_clean();
    sin = nrec;
    main_stim();
    pulse_dump();
    stall = 0;
    k = 0;
    while (mbusy && k < 100) begin
      out_ready = !(out_valid && out_id == 3'd2 && stall < 5);
      if (!out_ready) stall++;
      tick();
      k++;
    end
    out_ready = 1'b1;
    chk("bp stalls", 64'(stall), 64'd5);
    chk("bp records", 64'(nrec - sin), 64'd8);
    chk("bp ch0", {16'd0, got[0]}, 64'd30);
    chk("bp ch7", {16'd0, got[7]}, 64'd30);

    for (int r = 0; r < 5; r++) begin
      pulse_clean();
      log_enable = tab[r].le;
      for (int c = 0; c < tab[r].ncyc; c++) begin
        setinc(tab[r].ch, tab[r].incv);
        tick();
      end
      inc = '0;
      log_enable = 1'b1;
      pulse_dump();
      drain();
      chk($sformatf("table row %0d", r),
          {16'd0, got[tab[r].ch]}, {16'd0, tab[r].exp});
    end

    // clean and dump in the same cycle
    pulse_clean();
    for (int c = 0; c < 2; c++) begin
      setinc(1, 4'd10);
      tick();
    end
    inc = '0;
    clean = 1'b1;
    dump = 1'b1;
    tick();
    clean = 1'b0;
    dump = 1'b0;
    drain();
    chk("clean+dump snap", {16'd0, got[1]}, 64'd20);
    pulse_dump();
    drain();
    chk("after clean", {16'd0, got[1]}, 64'd0);

    // saturation on the narrow instance
    pulse_clean();
    for (int c = 0; c < 20; c++) begin
      setinc(3, 4'd15);
      tick();
    end
    inc = '0;
    pulse_dump();
    k = 0;
    while (mbusy && k < 100) begin
      if (out_valid && out_id == 3'd3) begin
        chk("sat u8 value", {56'd0, val8}, 64'd255);
        chk("sat u8 id", {61'd0, id8}, 64'd3);
      end
      tick();
      k++;
    end
    chk("sat wide ch3", {16'd0, got[3]}, 64'd300);

    // dumps while draining
    pulse_clean();
    for (int c = 0; c < 3; c++) begin
      setinc(4, 4'd2);
      tick();
    end
    inc = '0;
    sin = nrec;
    pulse_dump();
    k = 0;
    while (mbusy && k < 100) begin
      dump = out_valid &&
             (out_id == 3'd0 || out_id == 3'd3 || out_id == 3'd7);
      tick();
      dump = 1'b0;
      k++;
    end
    chk("drop records", 64'(nrec - sin), 64'd8);
    chk("drop count", {56'd0, dump_dropped}, 64'd3);
    chk("drop ch4", {16'd0, got[4]}, 64'd6);
    pulse_dump();
    chk("redump busy", {63'd0, busy}, 64'd1);

    // async reset mid-drain at id 4
    k = 0;
    while (!(out_valid && out_id == 3'd4) && k < 20) begin
      tick();
      k++;
    end
    chk("reach id 4", {61'd0, out_id}, 64'd4);
    #2;
    reset = 1'b1;
    #1;
    chk("arst out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst busy", {63'd0, busy}, 64'd0);
    chk("arst dropped", {56'd0, dump_dropped}, 64'd0);
    chk("arst u8 valid", {63'd0, v8}, 64'd0);
    sb.delete();
    mbusy = 1'b0;
    mid = 3'd0;
    mdrop = 8'd0;
    for (int i = 0; i < N; i++) mc[i] = '0;
    @(negedge clock);
    reset = 1'b0;
    timer = timer + 64'd1;
    for (int c = 0; c < 3; c++) begin
      setinc(6, 4'd5);
      tick();
    end
    inc = '0;
    pulse_dump();
    drain();
    chk("post rst ch6", {16'd0, got[6]}, 64'd15);
    chk("post rst ch4", {16'd0, got[4]}, 64'd0);
    chk("post rst ch0", {16'd0, got[0]}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
